// File: rtl/renkon_linebuf_pad.sv
// renkon_linebuf_pad -- padded line buffer for the renkon convolution unit.
//
// Walks the padded (P x P, P = img + 2*pad) coordinate space of one square
// feature map in raster order, pushing either an input pixel or an exact zero
// per position. The pushes are stacked through FSIZE-1 line memories, and the
// result is an FSIZE x FSIZE sliding window, emitted once per valid output
// position.
//
// Ports:
//   clk, xrst        clock, async active-low reset
//   buf_start        one-cycle frame start; latches img_size / pad_size
//   img_size         unpadded image edge (1..MAXW)
//   pad_size         zero pad per side (0..FSIZE/2)
//   in_valid/in_data pixel stream, consumed when in_ready & in_valid
//   in_ready         current position is an image pixel (not padding)
//   out_valid        out_data holds a complete window (one cycle)
//   out_data         window, element (i,j) at [(i*FSIZE+j)*DWIDTH +: DWIDTH]
//   out_last         last window of the frame
//   busy             a frame is in progress

// One line of history: a column-addressed memory with an async read, so the
// old value at column c and the new value enter the same push cycle.
module renkon_linebuf_row #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 34,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DWIDTH-1:0] din,
  output logic [DWIDTH-1:0] dout
);
  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[addr] <= din;

  assign dout = mem[addr];
endmodule

module renkon_linebuf_pad #(
  parameter int DWIDTH = 16,
  parameter int FSIZE  = 3,
  parameter int MAXW   = 32,
  parameter int LWIDTH = $clog2(MAXW+FSIZE),
  parameter int PWIDTH = $clog2(FSIZE)
) (
  input  logic                          clk,
  input  logic                          xrst,
  input  logic                          buf_start,
  input  logic [LWIDTH-1:0]             img_size,
  input  logic [PWIDTH-1:0]             pad_size,
  input  logic                          in_valid,
  input  logic [DWIDTH-1:0]             in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [FSIZE*FSIZE*DWIDTH-1:0] out_data,
  output logic                          out_last,
  output logic                          busy
);
  localparam int HALF  = FSIZE / 2;
  localparam int DEPTH = MAXW + 2*HALF;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [LWIDTH-1:0] FM1 = LWIDTH'(FSIZE-1);

  typedef enum logic {IDLE, RUN} state_t;
  typedef struct packed {
    logic [LWIDTH-1:0] r;
    logic [LWIDTH-1:0] c;
  } pos_t;

  state_t            state;
  pos_t              pos;
  logic [LWIDTH-1:0] pad_q;   // first image row/col
  logic [LWIDTH-1:0] hi_q;    // first trailing-pad row/col (pad + img)
  logic [LWIDTH-1:0] pm1_q;   // P - 1

  logic              is_pad, push, qual, lastpos;
  logic [DWIDTH-1:0] x;

  logic [FSIZE-2:0][DWIDTH-1:0]            lb_q, lb_d;
  logic [FSIZE-1:0][DWIDTH-1:0]            col;
  logic [FSIZE-1:0][FSIZE-1:0][DWIDTH-1:0] win;

  // ---------------------------------------------------------------- position
  assign is_pad  = (pos.r < pad_q) || (pos.c < pad_q) ||
                   (pos.r >= hi_q) || (pos.c >= hi_q);
  assign in_ready = (state == RUN) && !is_pad;
  // Padding never waits on the stream; image positions wait for in_valid.
  assign push    = (state == RUN) && (is_pad || in_valid);
  assign x       = is_pad ? '0 : in_data;
  // Row-wrap windows (c < FSIZE-1) mix two rows and are never qualified.
  assign qual    = (pos.r >= FM1) && (pos.c >= FM1);
  assign lastpos = (pos.r == pm1_q) && (pos.c == pm1_q);
  assign busy    = (state == RUN);

  // ------------------------------------------------------------ line memories
  // Line 0 holds the previous row, line k the row k+1 above the current one;
  // a push shifts the column down by one line.
  for (genvar k = 0; k < FSIZE-1; k++) begin : g_line
    if (k == 0) begin : g_first
      assign lb_d[k] = x;
    end else begin : g_next
      assign lb_d[k] = lb_q[k-1];
    end
    renkon_linebuf_row #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .AW(AW)) u_row (
      .clk  (clk),
      .we   (push),
      .addr (pos.c[AW-1:0]),
      .din  (lb_d[k]),
      .dout (lb_q[k])
    );
  end

  // Column vector, top (oldest row) to bottom (the value being pushed).
  for (genvar i = 0; i < FSIZE; i++) begin : g_col
    if (i == FSIZE-1) begin : g_new
      assign col[i] = x;
    end else begin : g_old
      assign col[i] = lb_q[FSIZE-2-i];
    end
  end

  // ------------------------------------------------------------------ window
  // Packed [i][j][bits] flattens to exactly the (i*FSIZE+j)*DWIDTH layout.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      win <= '0;
    end else if (push) begin
      for (int i = 0; i < FSIZE; i++) begin
        for (int j = 0; j < FSIZE-1; j++) win[i][j] <= win[i][j+1];
        win[i][FSIZE-1] <= col[i];
      end
    end
  end

  assign out_data = win;

  // --------------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state     <= IDLE;
      pos       <= '0;
      pad_q     <= '0;
      hi_q      <= '0;
      pm1_q     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= push && qual;
      out_last  <= push && qual && lastpos;
      case (state)
        IDLE: begin
          if (buf_start) begin
            state <= RUN;
            pos   <= '0;
            pad_q <= LWIDTH'(pad_size);
            hi_q  <= img_size + LWIDTH'(pad_size);
            pm1_q <= img_size + LWIDTH'({pad_size, 1'b0}) - LWIDTH'(1);
          end
        end
        RUN: begin
          if (push) begin
            if (pos.c == pm1_q) begin
              pos.c <= '0;
              pos.r <= pos.r + LWIDTH'(1);
              if (pos.r == pm1_q) state <= IDLE;
            end else begin
              pos.c <= pos.c + LWIDTH'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
